// File: rtl/datamemory_param.sv
// datamemory_param: MEM-stage data memory with byte/word loads and stores.
//
// The EX-stage result (ans_ex) is used as a byte address. The array is split
// into LANES byte-wide banks so that a byte store only enables one bank and the
// other lanes of the word keep their contents. Results are registered and
// appear one clock after the inputs.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (clears outputs, not the array)
//   ans_ex         ALU result: byte address, or pass-through value
//   DM_data        store data (byte stores use DM_data[7:0])
//   mem_rw_ex      0=load, 1=store
//   mem_en_ex      memory access enable
//   mem_size_ex    0=byte, 1=full word
//   mem_sext_ex    byte load: 1=sign-extend, 0=zero-extend
//   mem_mux_sel_dm 1=ans_dm from memory path, 0=ans_dm <= ans_ex
//   ans_dm         registered result to writeback
//   mem_valid_dm   one-cycle pulse after an accepted access
//   mem_err_dm     one-cycle pulse after a faulting access

// One byte-wide bank. Read is combinational; the top registers the result.
module datamemory_lane #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module datamemory_param #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 8,
  parameter int PASS_ON_WRITE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_rw_ex,
  input  logic              mem_en_ex,
  input  logic              mem_size_ex,
  input  logic              mem_sext_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              mem_valid_dm,
  output logic              mem_err_dm
);
  localparam int LANES  = DATA_W / 8;
  localparam int LB     = $clog2(LANES);
  localparam int STAGES = 1;

  logic [LB-1:0]          lane;
  logic [ADDR_W-1:0]      idx;
  logic                   oor, misal, bad, fault, acc_ok, wr_ok;
  logic [LANES-1:0][7:0]  rd;
  logic [7:0]             rbyte;
  logic [DATA_W-1:0]      ld_data, ans_nxt;
  logic [STAGES:1]        vld_pipe;

  assign lane  = ans_ex[LB-1:0];
  assign idx   = ans_ex[LB +: ADDR_W];
  // Any address bit above the word index means the access is out of range.
  assign oor   = |(ans_ex >> (LB + ADDR_W));
  assign misal = mem_size_ex & (lane != '0);
  assign bad   = oor | misal;
  assign fault = mem_en_ex & bad;
  assign acc_ok = mem_en_ex & ~bad;
  // Gating with reset drops a store whose edge lands while reset is low.
  // mem_en_ex is ANDed first so X on other inputs cannot raise a write enable.
  assign wr_ok = mem_en_ex & mem_rw_ex & ~bad & reset;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic       we;
    logic [7:0] wd;
    assign we = wr_ok & (mem_size_ex | (lane == LB'(i)));
    assign wd = mem_size_ex ? DM_data[8*i +: 8] : DM_data[7:0];
    datamemory_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .we    (we),
      .addr  (idx),
      .wdata (wd),
      .rdata (rd[i])
    );
  end

  assign rbyte   = rd[lane];
  assign ld_data = mem_size_ex ? DATA_W'(rd)
                               : {{(DATA_W-8){mem_sext_ex & rbyte[7]}}, rbyte};

  always_comb begin
    ans_nxt = ans_dm;
    if (!mem_mux_sel_dm)  ans_nxt = ans_ex;
    else if (fault)       ans_nxt = '0;
    else if (mem_en_ex) begin
      if (!mem_rw_ex)               ans_nxt = ld_data;
      else if (PASS_ON_WRITE != 0)  ans_nxt = DM_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ans_dm      <= '0;
      vld_pipe[1] <= 1'b0;
      mem_err_dm  <= 1'b0;
    end else begin
      ans_dm      <= ans_nxt;
      vld_pipe[1] <= acc_ok;
      mem_err_dm  <= fault;
    end
  end

  assign mem_valid_dm = vld_pipe[STAGES];
endmodule
